dma_copy_ctrl: RTL

Single-channel memory-to-memory DMA engine that copies a block of 32-bit words from one SDRAM region to another. It is programmed by the CPU through a small register port and drives the DMA-side Wishbone master port of the SDRAM arbiter. Each word is moved as one Wishbone read followed by one Wishbone write. Completion and timeout errors are reported through sticky status bits and a level interrupt.

---
 rtl/dma_copy_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dma_copy_ctrl.sv
// rtl/dma_copy_ctrl.sv - single-channel word-copy DMA engine on a Wishbone master port
module dma_copy_ctrl #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        dma_stb_o,
  output logic        dma_cyc_o,
  output logic        dma_we_o,
  output logic [3:0]  dma_sel_o,
  output logic [31:0] dma_adr_o,
  output logic [31:0] dma_dat_o,
  input  logic [31:0] dma_dat_i,
  input  logic        dma_ack_i,
  output logic        irq_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_GAP_W, S_WR, S_GAP_R
  } state_t;

  state_t             r_state, w_next;
  logic [31:0]        r_src, r_dst, r_buf;
  logic [LEN_W-1:0]   r_len;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_irq_en, r_done, r_err;

  logic               w_stb, w_ack, w_tmo, w_idle, w_ctrl_wr, w_start;
  logic [LEN_W-1:0]   w_len_next;

  assign w_idle     = (r_state == S_IDLE);
  assign w_stb      = (r_state == S_RD) || (r_state == S_WR);
  assign w_ack      = w_stb && dma_ack_i;
  // An ack in the final allowed cycle wins over the timeout.
  assign w_tmo      = w_stb && !dma_ack_i && (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_ctrl_wr  = cfg_we && (cfg_addr == 2'd3);
  assign w_start    = w_ctrl_wr && cfg_wdata[0] && w_idle;
  assign w_len_next = r_len - LEN_W'(1);
  assign irq_o      = (r_done || r_err) && r_irq_en;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    dma_stb_o = 1'b0;
    dma_cyc_o = 1'b0;
    dma_we_o  = 1'b0;
    dma_sel_o = 4'h0;
    dma_adr_o = 32'h0;
    dma_dat_o = 32'h0;
    case (r_state)
      S_IDLE: if (w_start && (r_len != '0)) w_next = S_RD;
      S_RD: begin
        dma_stb_o = 1'b1;
        dma_cyc_o = 1'b1;
        dma_sel_o = 4'hF;
        dma_adr_o = r_src;
        if (w_ack)      w_next = S_GAP_W;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_GAP_W: w_next = S_WR;
      S_WR: begin
        dma_stb_o = 1'b1;
        dma_cyc_o = 1'b1;
        dma_we_o  = 1'b1;
        dma_sel_o = 4'hF;
        dma_adr_o = r_dst;
        dma_dat_o = r_buf;
        if (w_ack)      w_next = (w_len_next == '0) ? S_IDLE : S_GAP_R;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_GAP_R: w_next = S_RD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src    <= 32'h0;
      r_dst    <= 32'h0;
      r_buf    <= 32'h0;
      r_len    <= '0;
      r_tmo    <= '0;
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // Counter idles at zero whenever stb is low, so each phase starts fresh.
      if (w_stb && !dma_ack_i) r_tmo <= r_tmo + TMO_W'(1);
      else                     r_tmo <= '0;

      if (cfg_we && w_idle) begin
        case (cfg_addr)
          2'd0:    r_src <= {cfg_wdata[31:2], 2'b00};
          2'd1:    r_dst <= {cfg_wdata[31:2], 2'b00};
          2'd2:    r_len <= cfg_wdata[LEN_W-1:0];
          default: ;
        endcase
      end

      if (w_ctrl_wr) begin
        r_irq_en <= cfg_wdata[1];
        if (cfg_wdata[2]) r_done <= 1'b0;
        if (cfg_wdata[3]) r_err  <= 1'b0;
      end

      if (w_start) begin
        r_err  <= 1'b0;
        r_done <= (r_len == '0);
      end

      if ((r_state == S_RD) && w_ack) r_buf <= dma_dat_i;

      if ((r_state == S_WR) && w_ack) begin
        r_src <= r_src + 32'd4;
        r_dst <= r_dst + 32'd4;
        r_len <= w_len_next;
        if (w_len_next == '0) r_done <= 1'b1;
      end

      if (w_tmo) r_err <= 1'b1;
    end
  end

  always_comb begin
    cfg_rdata = 32'h0;
    case (cfg_addr)
      2'd0:    cfg_rdata = r_src;
      2'd1:    cfg_rdata = r_dst;
      2'd2:    cfg_rdata = 32'(r_len);
      default: cfg_rdata = {27'h0, !w_idle, r_err, r_done, r_irq_en, 1'b0};
    endcase
  end

endmodule
